// File: rtl/mux_nx1_rr_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
//   Shared definitions for the registered N:1 streaming multiplexer.
//   - mode_e    : selection mode carried on the 1-bit 'mode' port
//   - wrap_inc  : channel-index increment modulo n (valid for any n >= 1,
//                 including non-power-of-2 channel counts)
// ---------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Next channel index after idx, wrapping n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx,
                                             input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_nx1_rr_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin search. Starting at ptr_i and wrapping modulo
//   N, finds the first channel whose valid bit is set.
//
//   Ports
//     valid_i  in   N     per-channel valid vector
//     ptr_i    in   SELW  search start index (expected < N)
//     found_o  out  1     at least one valid bit set
//     idx_o    out  SELW  index of first set bit at/after ptr_i (0 if none)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter  int unsigned N    = 4,
    localparam int unsigned SELW = $clog2(N)
) (
    input  logic [N-1:0]    valid_i,
    input  logic [SELW-1:0] ptr_i,
    output logic            found_o,
    output logic [SELW-1:0] idx_o
);

    int unsigned     cand;
    logic [SELW-1:0] cand_idx;

    always_comb begin
        found_o  = 1'b0;
        idx_o    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // Explicit subtract instead of '%' keeps the wrap cheap and
            // correct when N is not a power of two.
            cand = int'(ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = SELW'(cand);
            if (!found_o && valid_i[cand_idx]) begin
                found_o = 1'b1;
                idx_o   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_rr.sv
// ---------------------------------------------------------------------------
// mux_nx1_rr
//   Registered N-channel, W-bit multiplexer with valid/ready handshakes on
//   every input channel and on the output. Selection is either a fixed
//   channel index (mode 0) or round-robin arbitration (mode 1). The output
//   is a single pipeline register that loads whenever it is empty or being
//   drained in the same cycle, giving one beat per cycle without bubbles.
//
//   Ports
//     clk        in   1     rising-edge clock
//     rst_n      in   1     asynchronous active-low reset
//     mode       in   1     0 = fixed select, 1 = round-robin
//     sel        in   SELW  channel index used in fixed mode
//     in_data    in   N*W   channel k at bits [k*W +: W]
//     in_valid   in   N     per-channel valid
//     in_ready   out  N     per-channel ready (combinational, one-hot or 0)
//     out_data   out  W     registered data
//     out_chan   out  SELW  channel that supplied out_data
//     out_valid  out  1     registered valid
//     out_ready  in   1     consumer ready
// ---------------------------------------------------------------------------
module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter  int unsigned N    = 4,
    parameter  int unsigned W    = 8,
    localparam int unsigned SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_chan,
    output logic              out_valid,
    input  logic              out_ready
);

    // Output register and round-robin pointer
    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0] out_chan_q,  out_chan_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] ptr_q,       ptr_d;

    logic            load_en;
    logic            rr_found;
    logic [SELW-1:0] rr_idx;
    logic            grant_vld;
    logic [SELW-1:0] grant_idx;

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .valid_i (in_valid),
        .ptr_i   (ptr_q),
        .found_o (rr_found),
        .idx_o   (rr_idx)
    );

    // rst_n gates load_en so no producer sees in_ready while the block is
    // held in reset (the empty register would otherwise advertise space).
    always_comb begin
        load_en = rst_n && (!out_valid_q || out_ready);
    end

    // Candidate selection for the current mode
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (mode_e'(mode) == MODE_RR) begin
            grant_vld = rr_found;
            grant_idx = rr_idx;
        end else begin
            // Out-of-range sel never grants; the range test short-circuits
            // the valid lookup.
            if (int'(sel) < N && in_valid[sel]) begin
                grant_vld = 1'b1;
                grant_idx = sel;
            end
        end
    end

    // Ready is one-hot on the granted channel, only when the register can load
    always_comb begin
        in_ready = '0;
        if (load_en && grant_vld) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state for the output register and pointer
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (grant_vld) begin
                out_data_d  = in_data[int'(grant_idx)*W +: W];
                out_chan_d  = grant_idx;
                out_valid_d = 1'b1;
                if (mode_e'(mode) == MODE_RR) begin
                    ptr_d = SELW'(wrap_inc(int'(grant_idx), N));
                end
            end else begin
                // Drained with nothing to replace it: data/chan hold
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
module tb_mux_nx1_rr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance signals
    logic        mode4;
    logic [1:0]  sel4;
    logic [31:0] data4;
    logic [3:0]  v4;
    logic [3:0]  rdy4;
    logic [7:0]  od4;
    logic [1:0]  oc4;
    logic        ov4;
    logic        or4;

    // N=3 instance signals
    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] data3;
    logic [2:0]  v3;
    logic [2:0]  rdy3;
    logic [7:0]  od3;
    logic [1:0]  oc3;
    logic        ov3;
    logic        or3;

    int vectors = 0;
    int miscompares = 0;

    mux_nx1_rr #(.N(4), .W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode4), .sel(sel4),
        .in_data(data4), .in_valid(v4), .in_ready(rdy4),
        .out_data(od4), .out_chan(oc4), .out_valid(ov4), .out_ready(or4)
    );

    mux_nx1_rr #(.N(3), .W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_data(data3), .in_valid(v3), .in_ready(rdy3),
        .out_data(od3), .out_chan(oc3), .out_valid(ov3), .out_ready(or3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel the rules pick, or -1 for none.
    function automatic int pick(input int n, input logic m, input int s,
                                input logic [3:0] v, input int p);
        if (m == 1'b0) begin
            if (s < n && v[s]) return s;
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            int c;
            c = (p + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Reference state: output register contents and arbitration pointer
    logic [7:0] md4, md3;
    int         mc4, mc3, mp4, mp3;
    logic       mv4, mv3;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md4 = 8'h00; mc4 = 0; mv4 = 1'b0; mp4 = 0;
            md3 = 8'h00; mc3 = 0; mv3 = 1'b0; mp3 = 0;
        end else begin
            int g;
            if (!mv4 || or4) begin
                g = pick(4, mode4, int'(sel4), v4, mp4);
                if (g >= 0) begin
                    md4 = data4[g*8 +: 8]; mc4 = g; mv4 = 1'b1;
                    if (mode4) mp4 = (g + 1) % 4;
                end else begin
                    mv4 = 1'b0;
                end
            end
            if (!mv3 || or3) begin
                g = pick(3, mode3, int'(sel3), {1'b0, v3}, mp3);
                if (g >= 0) begin
                    md3 = data3[g*8 +: 8]; mc3 = g; mv3 = 1'b1;
                    if (mode3) mp3 = (g + 1) % 3;
                end else begin
                    mv3 = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the reference
    always @(negedge clk) begin
        int g;
        logic [3:0] er4;
        logic [2:0] er3;
        er4 = '0;
        er3 = '0;
        g = pick(4, mode4, int'(sel4), v4, mp4);
        if (rst_n && (!mv4 || or4) && g >= 0) er4[g] = 1'b1;
        g = pick(3, mode3, int'(sel3), {1'b0, v3}, mp3);
        if (rst_n && (!mv3 || or3) && g >= 0) er3[g] = 1'b1;
        chk("n4_in_ready",  32'(rdy4), 32'(er4));
        chk("n4_out_valid", 32'(ov4),  32'(mv4));
        chk("n4_out_data",  32'(od4),  32'(md4));
        chk("n4_out_chan",  32'(oc4),  32'(mc4));
        chk("n3_in_ready",  32'(rdy3), 32'(er3));
        chk("n3_out_valid", 32'(ov3),  32'(mv3));
        chk("n3_out_data",  32'(od3),  32'(md3));
        chk("n3_out_chan",  32'(oc3),  32'(mc3));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mode4 = 1'b0; sel4 = 2'd0; data4 = '0; v4 = 4'hF; or4 = 1'b1;
        mode3 = 1'b0; sel3 = 2'd0; data3 = '0; v3 = 3'h0; or3 = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        // Reset: nothing granted even though every channel is valid
        chk("rst_in_ready",  32'(rdy4), 32'h0);
        chk("rst_out_valid", 32'(ov4),  32'h0);
        chk("rst_out_data",  32'(od4),  32'h0);
        chk("rst_out_chan",  32'(oc4),  32'h0);
        v4 = 4'h0;
        rst_n = 1'b1;
        tick();

        // Fixed select, channel 2
        mode4 = 1'b0; sel4 = 2'd2; v4 = 4'b0100;
        data4 = {8'h44, 8'hA5, 8'h22, 8'h11};
        #1 chk("fix_in_ready", 32'(rdy4), 32'b0100);
        tick();
        v4 = 4'b0000;
        #1;
        chk("fix_out_valid", 32'(ov4), 32'h1);
        chk("fix_out_data",  32'(od4), 32'hA5);
        chk("fix_out_chan",  32'(oc4), 32'h2);
        tick();
        chk("fix_drain_valid", 32'(ov4), 32'h0);
        chk("fix_drain_hold",  32'(od4), 32'hA5);

        // Round-robin, all valid: 0,1,2,3,0,1,2,3,0,1
        mode4 = 1'b1; v4 = 4'hF; data4 = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rr_seq_chan",  32'(oc4), 32'(i % 4));
            chk("rr_seq_valid", 32'(ov4), 32'h1);
        end

        // Back-pressure: held beat from channel 1, pointer at 2
        or4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_in_ready", 32'(rdy4), 32'h0);
            chk("stall_chan",     32'(oc4),  32'h1);
            chk("stall_data",     32'(od4),  32'hB1);
        end
        or4 = 1'b1;
        #1 chk("release_in_ready", 32'(rdy4), 32'b0100);
        tick();
        chk("release_chan", 32'(oc4), 32'h2);
        chk("release_data", 32'(od4), 32'hC2);

        // Grants 3,0,1 leave pointer at 2 with a valid beat pending
        for (int i = 0; i < 3; i++) tick();
        chk("pre_rst_chan", 32'(oc4), 32'h1);

        // Async reset without a clock edge
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(ov4), 32'h0);
        chk("async_rst_data",  32'(od4), 32'h0);
        chk("async_rst_chan",  32'(oc4), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_chan",  32'(oc4), 32'h0);
        chk("post_rst_valid", 32'(ov4), 32'h1);
        v4 = 4'h0;

        // N=3 round-robin wrap 2 -> 0
        mode3 = 1'b1; v3 = 3'b111; data3 = {8'h32, 8'h31, 8'h30};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("n3_rr_chan", 32'(oc3), 32'(i % 3));
        end
        chk("n3_rr_data", 32'(od3), 32'h30);

        // N=3 fixed select of a nonexistent channel
        mode3 = 1'b0; sel3 = 2'd3;
        #1 chk("n3_sel3_ready", 32'(rdy3), 32'h0);
        tick();
        chk("n3_sel3_valid", 32'(ov3), 32'h0);
        chk("n3_sel3_hold",  32'(oc3), 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Registered N-channel, W-bit multiplexer with per-channel valid/ready handshakes and two selection modes: fixed select and round-robin arbitration. It generalises the team's combinational 4:1 gate-level mux into a streaming block that funnels N producer channels into one consumer. The output stage is a single pipeline register. The block sits between parallel datapath sources and a shared downstream sink.

## Interface
Parameters:
- N, 4, number of input channels (≥2)
- W, 8, data width per channel
- SELW, $clog2(N), localparam, width of channel index

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SELW  channel index used in mode 0
- in_data  input  N*W  channel k occupies bits [k*W +: W]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready; combinational, at most one bit high
- out_data  output  W  registered data
- out_chan  output  SELW  index of the channel that supplied out_data
- out_valid  output  1  registered valid
- out_ready  input  1  consumer ready

## Operation
- Internal state:
  - output register (out_data, out_chan, out_valid)
  - round-robin pointer ptr (SELW bits)
- load_en = !out_valid || out_ready. The register accepts a new beat when empty or being drained in the same cycle.
- Candidate selection:
  - Mode 0: candidate = sel. Grant only if sel < N and in_valid[sel].
  - Mode 1: scan ptr, ptr+1, … wrapping modulo N. Grant the first channel with in_valid set.
- Grant g occurs when load_en is high and a candidate exists.
  - in_ready[g] = 1; all other in_ready bits are 0.
  - When load_en = 0, in_ready = 0 regardless of in_valid.
- On grant (clock edge):
  - out_data <= in_data[g], out_chan <= g, out_valid <= 1.
  - In mode 1 only: ptr <= (g+1) mod N, wrapping N-1 → 0. This must be correct for non-power-of-2 N.
- load_en high with no grant: out_valid <= 0; out_data and out_chan hold.
- load_en low: the output register and ptr hold. Output is stable while out_valid && !out_ready.
- In mode 0, ptr holds its value.
- Mode or sel changes take effect combinationally in the same cycle; ptr is retained across mode switches.
- A channel must not see in_ready high unless its own in_valid is high.

## Timing
- Reset (async assert, sync release internally not required): out_valid = 0, out_data = 0, out_chan = 0, ptr = 0. in_ready = 0 during reset.
- Latency: 1 cycle from handshake (in_valid[g] && in_ready[g]) to out_valid.
- Throughput: 1 beat/cycle with out_ready held high; no bubble when out_ready and a new grant coincide.
- Simultaneous drain and load: the new beat replaces the old one on the same edge.
- Reset mid-transfer: any pending output beat is discarded. After release, arbitration restarts at channel 0.
- Mode 1 fairness: any continuously valid channel is granted within N grants.

## Structure
- Shared package mux_pkg holds:
  - MODE_FIXED = 1'b0, MODE_RR = 1'b1
  - the channel-index helper function (wrap-increment modulo N)
- One sub-module, rr_pick: purely combinational. Inputs are the valid vector and ptr; outputs are the found flag and the index of the first set bit at or after ptr with wraparound. Parametrised by N.
- Top level contains load_en, grant decode, the output register and ptr.

## Test plan
- Reset then mode 0, sel=2, in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1. Required: in_ready=4'b0100 for one cycle; next cycle out_valid=1, out_data=A5, out_chan=2.
- Mode 1, all in_valid=1111, out_ready=1 for 8 cycles. Required: out_chan sequence 0,1,2,3,0,1,2,3; in_ready one-hot each cycle.
- Mode 1, out_valid=1, out_ready=0 for 3 cycles with all inputs valid. Required: in_ready=0000; out_data and out_chan frozen; ptr unchanged. Then out_ready=1: the next grant goes to the held ptr channel.
- N=3 instance, mode 1, in_valid=3'b111. Required: out_chan 0,1,2,0, with ptr wrapping 2→0. Mode 0 with sel=3: no grant, in_ready=000, out_valid falls to 0.
- Assert rst_n low mid-stream (out_valid=1, ptr=2). Required: out_valid, out_data and out_chan go to 0 immediately without a clock edge. After release, mode 1 with in_valid=1111: first out_chan=0.
